// File: rtl/trace_pkg.sv
// Shared constants for the sphere-trace scheduler: miss code, object field slices,
// ray field widths and the scheduler FSM encoding.
package trace_pkg;

  localparam int T_W     = 10;
  localparam int COLOR_W = 12;
  localparam int RAD_W   = 8;
  localparam int CEN_W   = 28;
  localparam int OBJ_W   = COLOR_W + RAD_W + CEN_W;
  localparam int INIT_W  = 28;
  localparam int DIR_W   = 31;

  localparam logic [T_W-1:0] T_MISS = 10'h3FF;

  localparam int COLOR_HI = 47;
  localparam int COLOR_LO = 36;
  localparam int RAD_HI   = 35;
  localparam int RAD_LO   = 28;
  localparam int CEN_HI   = 27;
  localparam int CEN_LO   = 0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Strictly nearer than the current best; the miss code never wins.
  function automatic logic t_closer(input logic [T_W-1:0] t, input logic [T_W-1:0] best);
    return (t != T_MISS) && (t < best);
  endfunction

endpackage

// File: rtl/trace_tag_pipe.sv
// Shift pipe carrying {valid, idx, colour} alongside the tracer so each returned t
// can be matched to its sphere. Only the valid bits are reset.
module trace_tag_pipe #(
  parameter int DEPTH   = 4,
  parameter int IDX_W   = 4,
  parameter int COLOR_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [IDX_W-1:0]   in_idx,
  input  logic [COLOR_W-1:0] in_color,
  output logic               out_valid,
  output logic [IDX_W-1:0]   out_idx,
  output logic [COLOR_W-1:0] out_color,
  output logic               busy
);

  localparam int W = IDX_W + COLOR_W;

  logic [DEPTH-1:0] valid_reg;
  logic [W-1:0]     stage_reg [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg <= '0;
    end else begin
      valid_reg <= {valid_reg[DEPTH-2:0], in_valid};
    end
  end

  always_ff @(posedge clk) begin
    stage_reg[0] <= {in_idx, in_color};
    for (int i = 1; i < DEPTH; i++) begin
      stage_reg[i] <= stage_reg[i-1];
    end
  end

  assign out_valid = valid_reg[DEPTH-1];
  assign out_idx   = stage_reg[DEPTH-1][W-1:COLOR_W];
  assign out_color = stage_reg[DEPTH-1][COLOR_W-1:0];
  // Tags still travelling, excluding the one leaving this cycle.
  assign busy      = |valid_reg[DEPTH-2:0];

endmodule

// File: rtl/sphere_trace_scheduler.sv
// Streams every sphere of the object table through a pipelined tracer for one ray and
// returns the nearest hit (t, index, colour) over a valid/ready handshake.
module sphere_trace_scheduler
  import trace_pkg::*;
#(
  parameter int MAX_OBJ   = 16,
  parameter int TRACE_LAT = 4,
  parameter int OBJ_AW    = $clog2(MAX_OBJ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               ready,
  input  logic [INIT_W-1:0]  ray_init,
  input  logic [DIR_W-1:0]   ray_dir,
  input  logic [OBJ_AW:0]    num_obj,
  output logic [OBJ_AW-1:0]  obj_addr,
  input  logic [OBJ_W-1:0]   obj_data,
  output logic [INIT_W-1:0]  tr_init,
  output logic [DIR_W-1:0]   tr_dir,
  output logic [OBJ_W-1:0]   tr_object,
  input  logic [T_W-1:0]     tr_t,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_hit,
  output logic [T_W-1:0]     res_t,
  output logic [OBJ_AW-1:0]  res_idx,
  output logic [COLOR_W-1:0] res_color
);

  localparam logic [OBJ_AW:0] MAX_CNT = (OBJ_AW+1)'(MAX_OBJ);

  logic [1:0]          state_reg, state_next;
  logic [OBJ_AW-1:0]   issue_cnt_reg, last_idx_reg;
  logic                tag_in_vld_reg;
  logic [OBJ_AW-1:0]   tag_in_idx_reg;
  logic [T_W-1:0]      best_t_reg, best_t_next;
  logic [OBJ_AW-1:0]   best_idx_reg, best_idx_next;
  logic [COLOR_W-1:0]  best_color_reg, best_color_next;
  logic                res_hit_reg;
  logic [T_W-1:0]      res_t_reg;
  logic [OBJ_AW-1:0]   res_idx_reg;
  logic [COLOR_W-1:0]  res_color_reg;
  logic [INIT_W-1:0]   init_reg;
  logic [DIR_W-1:0]    dir_reg;

  logic                pipe_out_valid, pipe_busy;
  logic [OBJ_AW-1:0]   pipe_out_idx;
  logic [COLOR_W-1:0]  pipe_out_color;
  logic                accept, issue_last, drain_done;
  logic [OBJ_AW:0]     num_clamped;

  assign accept      = start && (state_reg == ST_IDLE);
  assign num_clamped = (num_obj > MAX_CNT) ? MAX_CNT : num_obj;
  assign issue_last  = (issue_cnt_reg == last_idx_reg);
  assign drain_done  = !tag_in_vld_reg && !pipe_busy;

  // The tag is registered once so it meets obj_data, which arrives a cycle after obj_addr.
  trace_tag_pipe #(
    .DEPTH   (TRACE_LAT),
    .IDX_W   (OBJ_AW),
    .COLOR_W (COLOR_W)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (tag_in_vld_reg),
    .in_idx    (tag_in_idx_reg),
    .in_color  (obj_data[COLOR_HI:COLOR_LO]),
    .out_valid (pipe_out_valid),
    .out_idx   (pipe_out_idx),
    .out_color (pipe_out_color),
    .busy      (pipe_busy)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (accept) state_next = (num_clamped == '0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE: if (issue_last) state_next = ST_DRAIN;
      ST_DRAIN: if (drain_done) state_next = ST_DONE;
      ST_DONE:  if (res_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Objects return in index order, so a strict compare leaves ties with the lower index.
  always_comb begin
    best_t_next     = best_t_reg;
    best_idx_next   = best_idx_reg;
    best_color_next = best_color_reg;
    if (pipe_out_valid && t_closer(tr_t, best_t_reg)) begin
      best_t_next     = tr_t;
      best_idx_next   = pipe_out_idx;
      best_color_next = pipe_out_color;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      issue_cnt_reg  <= '0;
      last_idx_reg   <= '0;
      tag_in_vld_reg <= 1'b0;
      tag_in_idx_reg <= '0;
      best_t_reg     <= T_MISS;
      best_idx_reg   <= '0;
      best_color_reg <= '0;
      res_hit_reg    <= 1'b0;
      res_t_reg      <= '0;
      res_idx_reg    <= '0;
      res_color_reg  <= '0;
      init_reg       <= '0;
      dir_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      tag_in_vld_reg <= (state_reg == ST_ISSUE);
      tag_in_idx_reg <= issue_cnt_reg;
      best_t_reg     <= best_t_next;
      best_idx_reg   <= best_idx_next;
      best_color_reg <= best_color_next;

      if (state_reg == ST_ISSUE) begin
        issue_cnt_reg <= issue_last ? '0 : issue_cnt_reg + OBJ_AW'(1);
      end

      if (accept) begin
        init_reg       <= ray_init;
        dir_reg        <= ray_dir;
        last_idx_reg   <= OBJ_AW'(num_clamped - (OBJ_AW+1)'(1));
        best_t_reg     <= T_MISS;
        best_idx_reg   <= '0;
        best_color_reg <= '0;
      end

      if (accept && num_clamped == '0) begin
        res_hit_reg   <= 1'b0;
        res_t_reg     <= T_MISS;
        res_idx_reg   <= '0;
        res_color_reg <= '0;
      end else if (state_reg == ST_DRAIN && drain_done) begin
        res_hit_reg   <= (best_t_next != T_MISS);
        res_t_reg     <= best_t_next;
        res_idx_reg   <= best_idx_next;
        res_color_reg <= best_color_next;
      end
    end
  end

  assign ready     = (state_reg == ST_IDLE);
  assign res_valid = (state_reg == ST_DONE);
  assign obj_addr  = issue_cnt_reg;
  assign tr_init   = init_reg;
  assign tr_dir    = dir_reg;
  assign tr_object = obj_data;
  assign res_hit   = res_hit_reg;
  assign res_t     = res_t_reg;
  assign res_idx   = res_idx_reg;
  assign res_color = res_color_reg;

endmodule

// File: tb/tb_sphere_trace_scheduler.sv
// Bench for sphere_trace_scheduler: sync object RAM model, delayed tracer model that
// returns t from the object's centre bits, and a nearest-hit reference per ray.
module tb_sphere_trace_scheduler;

  localparam int MAX_OBJ   = 16;
  localparam int OBJ_AW    = 4;
  localparam int TRACE_LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        ready;
  logic [27:0] ray_init = '0;
  logic [30:0] ray_dir = '0;
  logic [4:0]  num_obj = '0;
  logic [3:0]  obj_addr;
  logic [47:0] obj_data;
  logic [27:0] tr_init;
  logic [30:0] tr_dir;
  logic [47:0] tr_object;
  logic [9:0]  tr_t;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic        res_hit;
  logic [9:0]  res_t;
  logic [3:0]  res_idx;
  logic [11:0] res_color;

  int tests = 0;
  int fails = 0;

  logic [47:0] mem [MAX_OBJ];
  logic [9:0]  tdel [TRACE_LAT];
  logic [9:0]  t_tab [MAX_OBJ];
  logic [11:0] col_tab [MAX_OBJ];

  sphere_trace_scheduler #(.MAX_OBJ(MAX_OBJ), .TRACE_LAT(TRACE_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready),
    .ray_init(ray_init), .ray_dir(ray_dir), .num_obj(num_obj),
    .obj_addr(obj_addr), .obj_data(obj_data),
    .tr_init(tr_init), .tr_dir(tr_dir), .tr_object(tr_object), .tr_t(tr_t),
    .res_valid(res_valid), .res_ready(res_ready), .res_hit(res_hit),
    .res_t(res_t), .res_idx(res_idx), .res_color(res_color)
  );

  always #5 clk = ~clk;

  always @(posedge clk) obj_data <= mem[obj_addr];

  always @(posedge clk) begin
    tdel[0] <= tr_object[9:0];
    for (int k = 1; k < TRACE_LAT; k++) tdel[k] <= tdel[k-1];
  end
  assign tr_t = tdel[TRACE_LAT-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_table();
    for (int i = 0; i < MAX_OBJ; i++)
      mem[i] = {col_tab[i], 8'($urandom), 18'($urandom), t_tab[i]};
  endtask

  task automatic run_ray(input int n_req, input int hold, input string name);
    int          n, lat, addr_err, exp_lat;
    logic [9:0]  et;
    logic [3:0]  ei;
    logic [11:0] ec;
    logic [27:0] sv_init;
    logic [30:0] sv_dir;
    n = (n_req > MAX_OBJ) ? MAX_OBJ : n_req;
    exp_lat = (n == 0) ? 1 : n + TRACE_LAT + 2;
    et = 10'h3FF; ei = '0; ec = '0;
    for (int i = 0; i < n; i++)
      if (t_tab[i] < et) begin et = t_tab[i]; ei = 4'(i); ec = col_tab[i]; end
    load_table();
    sv_init = 28'($urandom);
    sv_dir  = 31'($urandom);
    ray_init = sv_init; ray_dir = sv_dir; num_obj = 5'(n_req); res_ready = 1'b0;
    check({name, "_ready_idle"}, 64'(ready), 64'(1));
    start = 1'b1;
    tick();
    start = 1'b0;
    ray_init = 28'($urandom); ray_dir = 31'($urandom); num_obj = 5'($urandom);
    check({name, "_ready_busy"}, 64'(ready), 64'(0));
    lat = 1; addr_err = 0;
    while (!res_valid && lat < 200) begin
      if (lat <= n && obj_addr !== 4'(lat - 1)) addr_err++;
      tick();
      lat++;
    end
    check({name, "_valid"}, 64'(res_valid), 64'(1));
    check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    check({name, "_addr_seq"}, 64'(addr_err), 64'(0));
    check({name, "_hit"}, 64'(res_hit), 64'(et != 10'h3FF));
    check({name, "_t"}, 64'(res_t), 64'(et));
    check({name, "_idx"}, 64'(res_idx), 64'(ei));
    check({name, "_color"}, 64'(res_color), 64'(ec));
    for (int h = 0; h < hold; h++) begin
      start = 1'b1; ray_init = 28'($urandom); num_obj = 5'($urandom);
      tick();
      check({name, "_hold"}, 64'({res_valid, ready, res_hit, res_t, res_idx, res_color}),
            64'({1'b1, 1'b0, et != 10'h3FF, et, ei, ec}));
    end
    start = 1'b0;
    check({name, "_tr_init"}, 64'(tr_init), 64'(sv_init));
    check({name, "_tr_dir"}, 64'(tr_dir), 64'(sv_dir));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({name, "_handshake"}, 64'({res_valid, ready}), 64'(2'b01));
  endtask

  initial begin
    for (int i = 0; i < MAX_OBJ; i++) begin t_tab[i] = 10'h3FF; col_tab[i] = 12'(i + 1); end
    load_table();
    #1 rst = 1'b0;
    #2;
    check("reset_outputs", 64'({ready, res_valid, res_hit, res_t, res_idx, res_color, obj_addr}),
          64'({1'b1, 1'b0, 1'b0, 10'h0, 4'h0, 12'h0, 4'h0}));
    tick(); tick();
    rst = 1'b1;
    tick();

    // Nearest of three
    for (int i = 0; i < MAX_OBJ; i++) col_tab[i] = 12'($urandom) | 12'h001;
    t_tab[0] = 10'd200; t_tab[1] = 10'd50; t_tab[2] = 10'd120;
    run_ray(3, 0, "near3");

    // All miss
    for (int i = 0; i < MAX_OBJ; i++) t_tab[i] = 10'h3FF;
    run_ray(4, 0, "allmiss");

    // Tie keeps lower index, then empty object list
    t_tab[0] = 10'd90; t_tab[1] = 10'd90; t_tab[2] = 10'd300;
    run_ray(3, 0, "tie");
    run_ray(0, 0, "zero");

    // Full table, reverse ordered
    for (int i = 0; i < MAX_OBJ; i++) t_tab[i] = 10'((15 - i) * 10);
    run_ray(16, 0, "full16");

    // Backpressure with ignored start pulses
    for (int i = 0; i < MAX_OBJ; i++) t_tab[i] = 10'($urandom_range(10, 900));
    run_ray(5, 10, "hold");

    // Reset in the middle of issue; stale tracer results carry t=1
    for (int i = 0; i < MAX_OBJ; i++) t_tab[i] = 10'd1;
    load_table();
    num_obj = 5'd8; ray_init = 28'($urandom);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    check("midray_addr", 64'(obj_addr), 64'(2));
    rst = 1'b0;
    #1;
    check("midray_reset", 64'({ready, res_valid, res_hit, res_t, res_idx, res_color, obj_addr}),
          64'({1'b1, 1'b0, 1'b0, 10'h0, 4'h0, 12'h0, 4'h0}));
    tick();
    rst = 1'b1;
    for (int i = 0; i < MAX_OBJ; i++) t_tab[i] = 10'($urandom_range(100, 900));
    run_ray(8, 0, "post_rst");

    // Random rays, including ties, misses and oversized num_obj
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < MAX_OBJ; i++) begin
        t_tab[i]   = ($urandom_range(0, 3) == 0) ? 10'h3FF : 10'($urandom_range(0, 40));
        col_tab[i] = 12'($urandom);
      end
      run_ray(int'($urandom_range(0, 24)), int'($urandom_range(0, 3)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
